// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: picks advance/hold/flush for PC and IF/ID,
// arbitrates redirects one-hot, and supervises a ready-handshake imem with a timeout.
module fetch_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Z_req,
    input  logic        J_req,
    input  logic        JR_req,
    input  logic        load_use,
    input  logic        mc_busy,
    input  logic        imem_ready,
    output logic        Z,
    output logic        J,
    output logic        JR,
    output logic        PC_IFWrite,
    output logic        IFID_Write,
    output logic        IF_flush,
    output logic        ID_flush,
    output logic        imem_req,
    output logic        fetch_err,
    output logic [15:0] stall_cycles
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_RUN,
        S_MEM_WAIT,
        S_MC_STALL,
        S_HALT
    } state_e;

    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   boot_cnt_q, boot_cnt_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            fetch_err_q, fetch_err_d;
    logic [15:0]     stall_q, stall_d;
    logic            redirect;
    logic            evaluate;
    logic            in_wait;

    assign redirect = JR_req | J_req | Z_req;
    assign in_wait  = (state_q == S_MEM_WAIT);

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path infers a latch.
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        fetch_err_d = fetch_err_q;
        stall_d     = stall_q;
        Z           = 1'b0;
        J           = 1'b0;
        JR          = 1'b0;
        PC_IFWrite  = 1'b0;
        IFID_Write  = 1'b0;
        IF_flush    = 1'b1;
        ID_flush    = 1'b1;
        imem_req    = 1'b0;
        evaluate    = 1'b0;

        if (!reset) begin
            unique case (state_q)
                S_BOOT: begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                    if (boot_cnt_q == BW'(BOOT_CYCLES - 1)) state_d = S_RUN;
                end
                S_RUN, S_MEM_WAIT, S_MC_STALL: evaluate = 1'b1;
                S_HALT: state_d = S_HALT;
                default: state_d = S_BOOT;
            endcase
        end

        // RUN, MEM_WAIT and MC_STALL share one priority chain; only the state bookkeeping differs.
        if (evaluate) begin
            imem_req = 1'b1;
            IF_flush = 1'b0;
            ID_flush = 1'b0;
            state_d  = S_RUN;
            if (mc_busy) begin
                state_d = in_wait ? S_MEM_WAIT : S_MC_STALL;
            end else if (redirect) begin
                JR         = JR_req;
                J          = J_req & ~JR_req;
                Z          = Z_req & ~J_req & ~JR_req;
                PC_IFWrite = 1'b1;
                IFID_Write = 1'b1;
                IF_flush   = 1'b1;
                ID_flush   = 1'b1;
                if (in_wait) begin
                    wait_cnt_d = '0;
                    state_d    = S_MEM_WAIT;
                end
            end else if (load_use) begin
                ID_flush = 1'b1;
            end else if (!imem_ready) begin
                IFID_Write = 1'b1;
                IF_flush   = 1'b1;
                state_d    = S_MEM_WAIT;
                if (!in_wait) begin
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
                        fetch_err_d = 1'b1;
                        state_d     = S_HALT;
                    end
                end
            end else begin
                PC_IFWrite = 1'b1;
                IFID_Write = 1'b1;
            end

            if (!PC_IFWrite && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_BOOT;
            boot_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            fetch_err_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
            stall_q     <= stall_d;
        end
    end

    assign fetch_err    = fetch_err_q;
    assign stall_cycles = stall_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage. Decides each cycle whether the PC and IF/ID register advance, hold or are flushed. Resolves simultaneous redirect requests (JR, J, branch-taken Z) into a single one-hot select for the fetch stage, and handles a ready-handshake instruction memory with a timeout. Sits between the ID/EX hazard and branch logic and the fetch stage, and drives that stage's Z/J/JR and PC_IFWrite inputs.

## Interface

- BOOT_CYCLES, default 4: cycles held in BOOT after reset before fetching starts (≥1).
- TIMEOUT, default 15: maximum consecutive MEM_WAIT cycles before a fetch error (≥1).

- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- Z_req, input, 1: branch taken, from EX.
- J_req, input, 1: jump, from ID.
- JR_req, input, 1: jump-register, from ID.
- load_use, input, 1: load-use hazard from ID. One-cycle pulse per hazard.
- mc_busy, input, 1: multi-cycle EX unit busy. Freezes the whole front end.
- imem_ready, input, 1: instruction memory has valid data for the current PC.
- Z, output, 1: branch select to fetch stage.
- J, output, 1: jump select to fetch stage.
- JR, output, 1: jump-register select to fetch stage.
- PC_IFWrite, output, 1: PC update enable.
- IFID_Write, output, 1: IF/ID register load enable.
- IF_flush, output, 1: load a bubble (NOP) into IF/ID.
- ID_flush, output, 1: load a bubble into ID/EX.
- imem_req, output, 1: fetch request.
- fetch_err, output, 1: sticky memory-timeout flag.
- stall_cycles, output, 16: saturating count of front-end stall cycles.

## Operation

- States: BOOT, RUN, MEM_WAIT, MC_STALL, HALT. The state register, wait counter, boot counter, fetch_err and stall_cycles are registered. All other outputs are combinational from state and inputs (Mealy).
- Redirect select is one-hot with priority JR_req > J_req > Z_req. Only the winner is driven high. Z, J and JR are never high together and are 0 whenever no redirect is accepted.
- **BOOT**
  - Outputs: PC_IFWrite=0, IFID_Write=0, IF_flush=1, ID_flush=1, imem_req=0.
  - Boot counter increments each cycle. After BOOT_CYCLES cycles, go to RUN.
- **RUN**, imem_req=1. Evaluated in priority order:
  1. mc_busy: all writes 0, flushes 0, selects 0. Go to MC_STALL.
  2. Any redirect: winner select=1, PC_IFWrite=1, IFID_Write=1, IF_flush=1, ID_flush=1. Stay in RUN. A redirect overrides load_use and imem_ready, because the fetched word is discarded.
  3. load_use: PC_IFWrite=0, IFID_Write=0, ID_flush=1. Stay in RUN.
  4. !imem_ready: PC_IFWrite=0, IFID_Write=1, IF_flush=1. Clear the wait counter and go to MEM_WAIT.
  5. Otherwise: PC_IFWrite=1, IFID_Write=1, no flushes.
- **MEM_WAIT**, imem_req=1.
  - mc_busy: same as RUN case 1, except the wait counter holds and the state stays MEM_WAIT.
  - Redirect: accepted exactly as in RUN case 2. The wait counter clears and the state stays MEM_WAIT.
  - imem_ready: behave as RUN case 5 (load_use still takes priority, as RUN case 3). Go to RUN.
  - Otherwise: behave as RUN case 4 and increment the wait counter. When the counter reaches TIMEOUT, set fetch_err and go to HALT.
- **MC_STALL**
  - Same outputs as RUN case 1.
  - When mc_busy falls, the cycle is evaluated as RUN and the state goes to RUN.
  - Redirect inputs are ignored while mc_busy is high; upstream holds them stable.
- **HALT**
  - Outputs as in BOOT. Only reset exits HALT.
- **stall_cycles**
  - Increments by 1 in every cycle where PC_IFWrite=0 and the state is RUN, MEM_WAIT or MC_STALL.
  - Saturates at 16'hFFFF; no wrap.

## Timing

- Reset values, in the cycle after reset is sampled high: state=BOOT, counters=0, fetch_err=0, stall_cycles=0.
- Output values during reset and BOOT: Z=J=JR=0, PC_IFWrite=0, IFID_Write=0, IF_flush=1, ID_flush=1, imem_req=0.
- Reset asserted in any state, including mid-MEM_WAIT or HALT, forces BOOT on the next edge and overrides every other input.
- First RUN cycle is exactly BOOT_CYCLES cycles after reset deasserts.
- Control outputs have zero-cycle latency from inputs within a state. State changes occur on the rising edge.
- The timeout fires at the edge ending the TIMEOUT-th consecutive not-ready cycle counted in MEM_WAIT. fetch_err is visible on the next cycle.
- Simultaneous events: mc_busy > redirect > load_use > imem_ready. A redirect arriving in the same cycle as imem_ready in MEM_WAIT is a redirect; the state stays MEM_WAIT.

## Test plan

- **Boot:** reset 1 cycle, BOOT_CYCLES=4, imem_ready=1.
  - Flushes high and PC_IFWrite=0 for 4 cycles.
  - PC_IFWrite=1 from cycle 5; stall_cycles=0.
- **Redirect priority:** in RUN, JR_req=J_req=Z_req=1 for 1 cycle.
  - JR=1, J=Z=0, PC_IFWrite=1, IF_flush=ID_flush=1.
  - Then J_req+Z_req gives J=1 only.
- **Load-use vs branch:** load_use=1 alone gives PC_IFWrite=0, IFID_Write=0, ID_flush=1, and stall_cycles goes 0→1. load_use=1 with Z_req=1 gives Z=1, PC_IFWrite=1.
- **Memory wait and timeout:**
  - imem_ready low 3 cycles, then high: IF_flush=1 for 3 cycles, RUN resumes, stall_cycles=3.
  - imem_ready held low with TIMEOUT=15: fetch_err=1 after 15 MEM_WAIT cycles; outputs frozen in HALT until reset.
- **mc_busy:** mc_busy high 5 cycles with J_req=1 throughout.
  - All writes 0 and J=0 during those 5 cycles.
  - In the cycle mc_busy falls: J=1, PC_IFWrite=1.
- **Reset mid-wait:** reset during MEM_WAIT at wait count 7 gives BOOT next cycle, with counters and fetch_err cleared.
